// File: rtl/bldc_hall_decoder_pkg.sv
// Shared types and helpers for decoding BLDC Hall sensors into commutation sectors.
package bldc_hall_decoder_pkg;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_CW   = 2'd1,
        DIR_CCW  = 2'd2
    } rotation_direction_t;

    typedef logic [2:0] hall_states_t;

    localparam int unsigned SECTOR_COUNT = 6;

    function automatic logic hall_code_valid(hall_states_t code);
        return (code != 3'b000) && (code != 3'b111);
    endfunction

    function automatic logic [2:0] hall_to_sector(hall_states_t code);
        logic [2:0] result;
        case (code)
            3'b101:  result = 3'd0;
            3'b100:  result = 3'd1;
            3'b110:  result = 3'd2;
            3'b010:  result = 3'd3;
            3'b011:  result = 3'd4;
            3'b001:  result = 3'd5;
            default: result = 3'd0;
        endcase
        return result;
    endfunction

    // (new - old) mod SECTOR_COUNT; 1 means one step CW, 5 one step CCW
    function automatic logic [2:0] sector_delta(logic [2:0] old_sector, logic [2:0] new_sector);
        logic [3:0] diff;
        diff = {1'b0, new_sector} + 4'(SECTOR_COUNT) - {1'b0, old_sector};
        if (diff >= 4'(SECTOR_COUNT)) begin
            diff = diff - 4'(SECTOR_COUNT);
        end
        return diff[2:0];
    endfunction

endpackage

// File: rtl/bldc_hall_decoder_if.sv
// Hall input pins and decoded rotor state outputs of bldc_hall_decoder.
interface bldc_hall_decoder_if #(
    parameter int unsigned PERIOD_WIDTH = 24
);
    import bldc_hall_decoder_pkg::*;

    logic [2:0]              hall_in;
    logic                    error_clear;
    hall_states_t            hall_values;
    logic [2:0]              sector;
    logic                    sector_valid;
    rotation_direction_t     dir;
    logic                    step;
    logic [PERIOD_WIDTH-1:0] period;
    logic                    period_valid;
    logic                    stalled;
    logic                    error;

    modport master (
        output hall_in, error_clear,
        input  hall_values, sector, sector_valid, dir, step,
               period, period_valid, stalled, error
    );

    modport slave (
        input  hall_in, error_clear,
        output hall_values, sector, sector_valid, dir, step,
               period, period_valid, stalled, error
    );

endinterface

// File: rtl/bldc_hall_debouncer.sv
// Two-flop synchroniser and stability counter; strobes accept with a newly settled Hall code.
module bldc_hall_debouncer
    import bldc_hall_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [2:0]   hall_in,
    output hall_states_t code,
    output logic         accept
);

    localparam int unsigned CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);

    logic [2:0]           sync1;
    logic [2:0]           sync2;
    logic [2:0]           cand;
    logic [2:0]           cand_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_next;
    logic                 accept_next;

    // cnt is the number of consecutive cycles the synchronised value has matched cand
    always_comb begin
        cand_next = cand;
        cnt_next  = cnt;
        if (sync2 != cand) begin
            cand_next = sync2;
            cnt_next  = CNT_WIDTH'(1);
        end else if (cnt < CNT_WIDTH'(DEBOUNCE_CYCLES)) begin
            cnt_next = cnt + 1'b1;
        end
        accept_next = (cnt_next == CNT_WIDTH'(DEBOUNCE_CYCLES)) && (cand_next != code);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '0;
            sync2  <= '0;
            cand   <= '0;
            cnt    <= '0;
            code   <= '0;
            accept <= 1'b0;
        end else begin
            sync1  <= hall_in;
            sync2  <= sync1;
            cand   <= cand_next;
            cnt    <= cnt_next;
            accept <= accept_next;
            if (accept_next) begin
                code <= cand_next;
            end
        end
    end

endmodule

// File: rtl/bldc_hall_decoder.sv
// Hall decoder top: sector tracking, direction, step-period measurement, stall timeout, sticky error.
module bldc_hall_decoder
    import bldc_hall_decoder_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned PERIOD_WIDTH    = 24,
    parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
    input logic                clk,
    input logic                rst,
    bldc_hall_decoder_if.slave bus
);

    hall_states_t            code;
    logic                    accept;

    hall_states_t            hall_values_reg;
    logic [2:0]              sector_reg;
    logic                    sector_valid_reg;
    rotation_direction_t     dir_reg;
    rotation_direction_t     last_dir;
    logic                    step_reg;
    logic [PERIOD_WIDTH-1:0] period_reg;
    logic                    period_valid_reg;
    logic                    stalled_reg;
    logic                    error_reg;
    logic [PERIOD_WIDTH-1:0] cnt;

    logic                    new_valid;
    logic [2:0]              new_sector;
    logic [2:0]              delta;
    logic                    step_now;
    rotation_direction_t     step_dir;
    logic                    fault;
    logic                    timed_out;

    bldc_hall_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk    (clk),
        .rst    (rst),
        .hall_in(bus.hall_in),
        .code   (code),
        .accept (accept)
    );

    always_comb begin
        new_valid  = hall_code_valid(code);
        new_sector = hall_to_sector(code);
        delta      = sector_delta(sector_reg, new_sector);
        step_now   = 1'b0;
        step_dir   = DIR_NONE;
        fault      = 1'b0;
        if (accept) begin
            if (!new_valid) begin
                fault = 1'b1;
            end else if (sector_valid_reg) begin
                if (delta == 3'd1) begin
                    step_now = 1'b1;
                    step_dir = DIR_CW;
                end else if (delta == 3'd5) begin
                    step_now = 1'b1;
                    step_dir = DIR_CCW;
                end else begin
                    fault = 1'b1;
                end
            end
        end
        timed_out = (cnt >= PERIOD_WIDTH'(TIMEOUT_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hall_values_reg  <= '0;
            sector_reg       <= '0;
            sector_valid_reg <= 1'b0;
            dir_reg          <= DIR_NONE;
            last_dir         <= DIR_NONE;
            step_reg         <= 1'b0;
            period_reg       <= '0;
            period_valid_reg <= 1'b0;
            stalled_reg      <= 1'b1;
            error_reg        <= 1'b0;
            cnt              <= '0;
        end else begin
            step_reg <= step_now;
            if (accept) begin
                hall_values_reg  <= code;
                sector_valid_reg <= new_valid;
                if (new_valid) begin
                    sector_reg <= new_sector;
                end
            end

            // Restarting at 1 makes cnt equal the step-to-step distance on the next step edge
            if (step_now) begin
                cnt <= PERIOD_WIDTH'(1);
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end

            // last_dir == DIR_NONE marks "no usable previous step" after reset, fault or stall
            if (step_now) begin
                dir_reg     <= step_dir;
                last_dir    <= step_dir;
                stalled_reg <= 1'b0;
                if (last_dir == step_dir) begin
                    period_reg       <= cnt;
                    period_valid_reg <= 1'b1;
                end else begin
                    period_valid_reg <= 1'b0;
                end
            end else if (fault) begin
                dir_reg          <= DIR_NONE;
                last_dir         <= DIR_NONE;
                period_valid_reg <= 1'b0;
            end else if (timed_out) begin
                stalled_reg      <= 1'b1;
                dir_reg          <= DIR_NONE;
                last_dir         <= DIR_NONE;
                period_valid_reg <= 1'b0;
            end

            if (fault) begin
                error_reg <= 1'b1;
            end else if (bus.error_clear) begin
                error_reg <= 1'b0;
            end
        end
    end

    assign bus.hall_values  = hall_values_reg;
    assign bus.sector       = sector_reg;
    assign bus.sector_valid = sector_valid_reg;
    assign bus.dir          = dir_reg;
    assign bus.step         = step_reg;
    assign bus.period       = period_reg;
    assign bus.period_valid = period_valid_reg;
    assign bus.stalled      = stalled_reg;
    assign bus.error        = error_reg;

endmodule
